ad_mcs_sync_seq: RTL and testbench
==================================

AD_MCS_SYNC_SEQ -- requirements
Module: ad_mcs_sync_seq

Interface
REQ-001 Parameter NUM_CHIPS, default 2: number of AD9361 devices sequenced (1..8).
REQ-002 Parameter PULSE_W, default 8: mcs_sync high time in clocks (>=1).
REQ-003 Parameter GAP_W, default 64: low time after each pulse, and post-reset settle time, in clocks (>=1).
REQ-004 Parameter NUM_PULSES, default 2: sync pulses per sequence (1..15).
REQ-005 Parameter RESET_HOLD, default 16: resetb low time in clocks (>=1).
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset: up_clk in 1, the single clock; up_rstn in 1, the asynchronous active-low reset.
REQ-007 Port start, in, 1: one-cycle sequence request.
REQ-008 Port mode, in, 1: 0 = sync only; 1 = reset chips, then sync.
REQ-009 Port abort, in, 1: terminate the active sequence.
REQ-010 Port chip_mask, in, NUM_CHIPS: participating chips.
REQ-011 Port gpio_status_in, in, 8*NUM_CHIPS: asynchronous CTRL_OUT buses.
REQ-012 Port gpio_status, out, 8*NUM_CHIPS: synchronised CTRL_OUT.
REQ-013 Port mcs_sync, out, 1: shared multi-chip sync strobe.
REQ-014 Port resetb, out, NUM_CHIPS: per-chip active-low reset.
REQ-015 Port busy, out, 1: sequence in progress.
REQ-016 Port done, out, 1: one-cycle completion pulse.
REQ-017 Port aborted, out, 1: one-cycle abort pulse.
REQ-018 Port err, out, 1: one-cycle rejected-start pulse.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 The FSM SHALL have the states IDLE, RST_LOW, RST_WAIT, PULSE, GAP and DONE.
REQ-021 In IDLE, start=1 with a nonzero chip_mask SHALL latch chip_mask and mode, and enter RST_LOW if mode=1 or PULSE if mode=0.
REQ-022 The first action SHALL appear the cycle after start is sampled.
REQ-023 start in IDLE with chip_mask=0 SHALL stay in IDLE and pulse err for one cycle.
REQ-024 start while busy=1 SHALL be ignored, with no err.
REQ-025 RST_LOW: resetb[i]=0 for each latched mask bit, for RESET_HOLD cycles; unmasked bits SHALL stay 1.
REQ-026 RST_WAIT: all resetb=1 for GAP_W cycles, then go to PULSE.
REQ-027 PULSE: mcs_sync=1 for PULSE_W cycles, then go to GAP.
REQ-028 GAP: mcs_sync=0 for GAP_W cycles; then go to PULSE if fewer than NUM_PULSES pulses are issued, else go to DONE.
REQ-029 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-030 busy SHALL be 1 in RST_LOW, RST_WAIT, PULSE and GAP, and 0 otherwise.
REQ-031 There SHALL be a single down-counter of width clog2(max(PULSE_W,GAP_W,RESET_HOLD))+1, loaded with N-1 on state entry, with exit at 0; there SHALL be no wrap.
REQ-032 The pulse counter SHALL be 4 bits and clear on start.
REQ-033 abort=1 in any busy state SHALL, on the next cycle, give IDLE, mcs_sync=0, all resetb=1, busy=0 and aborted=1 for one cycle, with no done.
REQ-034 abort with start in the same cycle while in IDLE: abort wins; start is dropped, with no err and no aborted.
REQ-035 abort in DONE or IDLE SHALL have no effect.
REQ-036 chip_mask and mode changes while busy SHALL have no effect until the next accepted start.
REQ-037 gpio_status SHALL be gpio_status_in passed through a two-flop synchroniser per bit, with 2-cycle latency, independent of the FSM.

Reset
REQ-038 up_rstn=0 SHALL asynchronously force: state IDLE, mcs_sync=0, resetb all 1, busy=0, done=0, aborted=0, err=0, gpio_status all 0, counters 0.
REQ-039 Reset asserted mid-sequence SHALL abandon the sequence with no done or aborted pulse.
REQ-040 After up_rstn deasserts, the first start SHALL be accepted.

Verification (defaults; start sampled at cycle 0)
REQ-041 mode=0, mask=2'b11 -> mcs_sync high cycles 1-8 and 73-80; busy cycles 1-144; done at cycle 145; resetb stays 2'b11.
REQ-042 mode=1, mask=2'b10 -> resetb=2'b01 cycles 1-16; mcs_sync high cycles 81-88 and 153-160; done at cycle 225.
REQ-043 mode=0, abort at cycle 5 -> mcs_sync=0 and aborted=1 at cycle 6; busy=0 from cycle 6; done never asserts.
REQ-044 start with mask=0 -> err=1 at cycle 1; busy stays 0. A second start at cycle 50 while busy is ignored.
REQ-045 up_rstn pulsed low at cycle 20 of a mode=1 run -> resetb=2'b11 and mcs_sync=0 immediately. A new start after release gives nominal REQ-042 timing.
REQ-046 gpio_status_in toggled -> gpio_status follows exactly 2 cycles later; it is unaffected by abort or start.

Source files
------------

// File: rtl/ad_mcs_sync_seq_if.sv
// Control, status and chip-facing signals of the AD9361 multi-chip sync sequencer.
// master drives requests and raw CTRL_OUT; slave is the sequencer itself.
interface ad_mcs_sync_seq_if #(
   parameter int NUM_CHIPS = 2
);
   logic                   start;
   logic                   mode;
   logic                   abort;
   logic [NUM_CHIPS-1:0]   chip_mask;
   logic [8*NUM_CHIPS-1:0] gpio_status_in;
   logic [8*NUM_CHIPS-1:0] gpio_status;
   logic                   mcs_sync;
   logic [NUM_CHIPS-1:0]   resetb;
   logic                   busy;
   logic                   done;
   logic                   aborted;
   logic                   err;

   modport master (
      output start,
      output mode,
      output abort,
      output chip_mask,
      output gpio_status_in,
      input  gpio_status,
      input  mcs_sync,
      input  resetb,
      input  busy,
      input  done,
      input  aborted,
      input  err
   );

   modport slave (
      input  start,
      input  mode,
      input  abort,
      input  chip_mask,
      input  gpio_status_in,
      output gpio_status,
      output mcs_sync,
      output resetb,
      output busy,
      output done,
      output aborted,
      output err
   );
endinterface

// File: rtl/ad_mcs_sync_seq.sv
// Sequences optional per-chip reset then NUM_PULSES mcs_sync pulses; all outputs registered, first action 1 cycle after start.
// No backpressure: start is dropped while busy, abort ends a sequence next cycle; CTRL_OUT passes through a 2-flop synchroniser.
module ad_mcs_sync_seq #(
   parameter int NUM_CHIPS  = 2,
   parameter int PULSE_W    = 8,
   parameter int GAP_W      = 64,
   parameter int NUM_PULSES = 2,
   parameter int RESET_HOLD = 16
) (
   input logic              up_clk,
   input logic              up_rstn,
   ad_mcs_sync_seq_if.slave bus
);

   localparam int MAX_PG = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int MAX_W  = (MAX_PG > RESET_HOLD) ? MAX_PG : RESET_HOLD;
   localparam int CW     = $clog2(MAX_W) + 1;

   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W - 1);
   localparam logic [CW-1:0] RST_LD   = CW'(RESET_HOLD - 1);
   localparam logic [3:0]    NP       = 4'(NUM_PULSES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST_LOW,
      S_RST_WAIT,
      S_PULSE,
      S_GAP,
      S_DONE
   } state_t;

   state_t                 r_state;
   logic [CW-1:0]          r_cnt;
   logic [3:0]             r_pcnt;
   logic [NUM_CHIPS-1:0]   r_mask;
   logic                   r_mcs_sync;
   logic [NUM_CHIPS-1:0]   r_resetb;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_aborted;
   logic                   r_err;
   logic [8*NUM_CHIPS-1:0] r_gpio_meta;
   logic [8*NUM_CHIPS-1:0] r_gpio_sync;

   state_t                 w_state_nxt;
   logic [CW-1:0]          w_cnt_nxt;
   logic [3:0]             w_pcnt_nxt;
   logic [NUM_CHIPS-1:0]   w_mask_nxt;
   logic                   w_cnt_zero;
   logic                   w_busy_cur;
   logic                   w_busy_nxt;
   logic                   w_accept;
   logic                   w_err;
   logic                   w_abort;

   assign w_cnt_zero = (r_cnt == '0);
   assign w_busy_cur = (r_state == S_RST_LOW) || (r_state == S_RST_WAIT) ||
                       (r_state == S_PULSE)   || (r_state == S_GAP);
   assign w_busy_nxt = (w_state_nxt == S_RST_LOW) || (w_state_nxt == S_RST_WAIT) ||
                       (w_state_nxt == S_PULSE)   || (w_state_nxt == S_GAP);

   // abort outranks start in IDLE: the request is dropped silently
   assign w_accept = (r_state == S_IDLE) && bus.start && !bus.abort && (|bus.chip_mask);
   assign w_err    = (r_state == S_IDLE) && bus.start && !bus.abort && (bus.chip_mask == '0);
   assign w_abort  = w_busy_cur && bus.abort;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pcnt_nxt  = r_pcnt;
      w_mask_nxt  = r_mask;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_mask_nxt = bus.chip_mask;
               w_pcnt_nxt = '0;
               if (bus.mode) begin
                  w_state_nxt = S_RST_LOW;
                  w_cnt_nxt   = RST_LD;
               end else begin
                  w_state_nxt = S_PULSE;
                  w_cnt_nxt   = PULSE_LD;
               end
            end
         end
         S_RST_LOW: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_RST_WAIT;
               w_cnt_nxt   = GAP_LD;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_RST_WAIT: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_PULSE;
               w_cnt_nxt   = PULSE_LD;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_PULSE: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = GAP_LD;
               w_pcnt_nxt  = r_pcnt + 4'd1;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_GAP: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (r_pcnt < NP) begin
               w_state_nxt = S_PULSE;
               w_cnt_nxt   = PULSE_LD;
            end else begin
               w_state_nxt = S_DONE;
               w_cnt_nxt   = '0;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      if (w_abort) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end
   end

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_pcnt  <= '0;
         r_mask  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pcnt  <= w_pcnt_nxt;
         r_mask  <= w_mask_nxt;
      end
   end

   // outputs decode the next state so they line up with the state they describe
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_mcs_sync <= 1'b0;
         r_resetb   <= '1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_aborted  <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_mcs_sync <= (w_state_nxt == S_PULSE);
         r_resetb   <= (w_state_nxt == S_RST_LOW) ? ~w_mask_nxt : '1;
         r_busy     <= w_busy_nxt;
         r_done     <= (w_state_nxt == S_DONE);
         r_aborted  <= w_abort;
         r_err      <= w_err;
      end
   end

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_gpio_meta <= '0;
         r_gpio_sync <= '0;
      end else begin
         r_gpio_meta <= bus.gpio_status_in;
         r_gpio_sync <= r_gpio_meta;
      end
   end

   assign bus.mcs_sync    = r_mcs_sync;
   assign bus.resetb      = r_resetb;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.aborted     = r_aborted;
   assign bus.err         = r_err;
   assign bus.gpio_status = r_gpio_sync;

endmodule

// File: tb/tb_ad_mcs_sync_seq.sv
// Bench for ad_mcs_sync_seq: timeline model of the sequence checked every cycle,
// directed scenarios with literal expectations, then randomized start/abort/mask/mode traffic.
module tb_ad_mcs_sync_seq;

   localparam int NC = 2;
   localparam int PW = 8;
   localparam int GW = 64;
   localparam int NP = 2;
   localparam int RH = 16;

   logic up_clk  = 1'b0;
   logic up_rstn = 1'b0;
   int   cyc     = 0;
   int   errors  = 0;
   int   checks  = 0;

   ad_mcs_sync_seq_if #(.NUM_CHIPS(NC)) bus ();

   ad_mcs_sync_seq #(
      .NUM_CHIPS (NC),
      .PULSE_W   (PW),
      .GAP_W     (GW),
      .NUM_PULSES(NP),
      .RESET_HOLD(RH)
   ) dut (
      .up_clk (up_clk),
      .up_rstn(up_rstn),
      .bus    (bus.slave)
   );

   always #5 up_clk = ~up_clk;
   always @(posedge up_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // sequence timeline: k counts cycles after the one in which start was sampled
   function automatic int seq_len(input bit md);
      return (md ? RH + GW : 0) + NP * (PW + GW);
   endfunction

   function automatic bit exp_mcs(input bit md, input int k);
      int r;
      r = md ? RH + GW : 0;
      if (k < 1 || k > seq_len(md) || k <= r) return 1'b0;
      return ((k - r - 1) % (PW + GW)) < PW;
   endfunction

   function automatic logic [NC-1:0] exp_resetb(input bit md, input logic [NC-1:0] m, input int k);
      if (md && k >= 1 && k <= RH) return ~m;
      return '1;
   endfunction

   bit                 m_active   = 1'b0;
   int                 m_st       = 0;
   bit                 m_md       = 1'b0;
   logic [NC-1:0]      m_msk      = '0;
   bit                 m_pend_ab  = 1'b0;
   bit                 m_pend_err = 1'b0;
   logic [8*NC-1:0]    m_gq[$];

   always @(negedge up_clk) begin
      int k;
      int len;
      bit in_busy, in_done, idle;
      logic e_mcs, e_busy, e_done, e_ab, e_err;
      logic [NC-1:0] e_rb;
      logic [8*NC-1:0] e_g;
      k = cyc - m_st;
      len = seq_len(m_md);
      in_busy = m_active && k >= 1 && k <= len;
      in_done = m_active && k == len + 1;
      if (!up_rstn) begin
         e_mcs = 0; e_rb = '1; e_busy = 0; e_done = 0; e_ab = 0; e_err = 0; e_g = '0;
      end else begin
         e_mcs  = m_active ? exp_mcs(m_md, k) : 1'b0;
         e_rb   = m_active ? exp_resetb(m_md, m_msk, k) : '1;
         e_busy = in_busy;
         e_done = in_done;
         e_ab   = m_pend_ab;
         e_err  = m_pend_err;
         e_g    = (m_gq.size() == 2) ? m_gq[0] : '0;
      end
      chk("mcs_sync", bus.mcs_sync, e_mcs);
      chk("resetb", bus.resetb, e_rb);
      chk("busy", bus.busy, e_busy);
      chk("done", bus.done, e_done);
      chk("aborted", bus.aborted, e_ab);
      chk("err", bus.err, e_err);
      chk("gpio_status", bus.gpio_status, e_g);

      if (!up_rstn) begin
         m_active = 0; m_pend_ab = 0; m_pend_err = 0;
         m_gq = '{'0, '0};
      end else begin
         idle       = !in_busy && !in_done;
         m_pend_ab  = in_busy && bus.abort;
         if (m_pend_ab) m_active = 0;
         m_pend_err = idle && bus.start && !bus.abort && (bus.chip_mask == '0);
         if (idle && bus.start && !bus.abort && (bus.chip_mask != '0)) begin
            m_active = 1; m_st = cyc; m_md = bus.mode; m_msk = bus.chip_mask;
         end
         if (m_gq.size() == 2) void'(m_gq.pop_front());
         m_gq.push_back(bus.gpio_status_in);
      end
   end

   initial begin
      bus.gpio_status_in = '0;
      forever begin
         @(posedge up_clk);
         #2;
         bus.gpio_status_in = 16'($urandom);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1);
   end

   task automatic step();
      @(posedge up_clk);
      #2;
   endtask

   task automatic go(input int n);
      while (cyc < n) step();
   endtask

   task automatic wait_neg(input int n);
      do @(negedge up_clk); while (cyc < n);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   initial begin
      int s;
      bus.start = 0; bus.mode = 0; bus.abort = 0; bus.chip_mask = '0;

      chk("pin_len_m0", seq_len(0), 144);
      chk("pin_len_m1", seq_len(1), 224);
      chk("pin_mcs_m0_k8", exp_mcs(0, 8), 1);
      chk("pin_mcs_m0_k9", exp_mcs(0, 9), 0);
      chk("pin_mcs_m0_k73", exp_mcs(0, 73), 1);
      chk("pin_mcs_m1_k80", exp_mcs(1, 80), 0);
      chk("pin_mcs_m1_k153", exp_mcs(1, 153), 1);
      chk("pin_rb_m1_k16", exp_resetb(1, 2'b10, 16), 2'b01);

      repeat (3) step();
      chk("rst_busy", bus.busy, 0);
      chk("rst_resetb", bus.resetb, 2'b11);
      up_rstn = 1'b1;
      step();

      // sync only, both chips; abort during DONE must not matter
      bus.mode = 0; bus.chip_mask = 2'b11; s = cyc;
      pulse_start();
      wait_neg(s + 1);   chk("d0_mcs_1", bus.mcs_sync, 1);
      wait_neg(s + 8);   chk("d0_mcs_8", bus.mcs_sync, 1);
      wait_neg(s + 9);   chk("d0_mcs_9", bus.mcs_sync, 0);
      wait_neg(s + 73);  chk("d0_mcs_73", bus.mcs_sync, 1);
      wait_neg(s + 81);  chk("d0_mcs_81", bus.mcs_sync, 0);
      wait_neg(s + 144); chk("d0_busy_144", bus.busy, 1);
      chk("d0_resetb", bus.resetb, 2'b11);
      go(s + 145);
      bus.abort = 1'b1;
      wait_neg(s + 145); chk("d0_done_145", bus.done, 1); chk("d0_busy_145", bus.busy, 0);
      step();
      bus.abort = 1'b0;
      wait_neg(s + 146); chk("d0_no_abort_in_done", bus.aborted, 0);
      step();

      // reset then sync on chip 1; mask/mode changes mid-run are ignored
      bus.mode = 1; bus.chip_mask = 2'b10; s = cyc;
      pulse_start();
      bus.mode = 0; bus.chip_mask = 2'b01;
      wait_neg(s + 1);   chk("d1_rb_1", bus.resetb, 2'b01);
      wait_neg(s + 16);  chk("d1_rb_16", bus.resetb, 2'b01);
      wait_neg(s + 17);  chk("d1_rb_17", bus.resetb, 2'b11);
      wait_neg(s + 81);  chk("d1_mcs_81", bus.mcs_sync, 1);
      wait_neg(s + 160); chk("d1_mcs_160", bus.mcs_sync, 1);
      wait_neg(s + 225); chk("d1_done_225", bus.done, 1);
      step();

      // abort at cycle 5
      bus.mode = 0; bus.chip_mask = 2'b11; s = cyc;
      pulse_start();
      go(s + 5);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      wait_neg(s + 6); chk("ab_aborted", bus.aborted, 1); chk("ab_mcs", bus.mcs_sync, 0);
      chk("ab_busy", bus.busy, 0);
      wait_neg(s + 7); chk("ab_one_cycle", bus.aborted, 0);
      go(s + 160);

      // empty mask, then a start while busy
      bus.chip_mask = 2'b00; s = cyc;
      pulse_start();
      wait_neg(s + 1); chk("err_pulse", bus.err, 1); chk("err_busy", bus.busy, 0);
      wait_neg(s + 2); chk("err_one_cycle", bus.err, 0);
      step();
      bus.chip_mask = 2'b11; s = cyc;
      pulse_start();
      go(s + 50);
      bus.chip_mask = 2'b00;
      pulse_start();
      wait_neg(s + 51); chk("busy_start_no_err", bus.err, 0); chk("busy_start_busy", bus.busy, 1);
      go(s + 147);

      // abort with start in IDLE
      bus.chip_mask = 2'b11; bus.abort = 1'b1; s = cyc;
      pulse_start();
      bus.abort = 1'b0;
      wait_neg(s + 1); chk("idle_ab_busy", bus.busy, 0); chk("idle_ab_aborted", bus.aborted, 0);
      step();

      // reset mid-sequence, then a nominal reset+sync run
      bus.mode = 1; bus.chip_mask = 2'b10; s = cyc;
      pulse_start();
      go(s + 20);
      up_rstn = 1'b0;
      #1;
      chk("mrst_resetb", bus.resetb, 2'b11);
      chk("mrst_mcs", bus.mcs_sync, 0);
      chk("mrst_busy", bus.busy, 0);
      step(); step();
      up_rstn = 1'b1; s = cyc;
      pulse_start();
      wait_neg(s + 1);   chk("mrst_rb_1", bus.resetb, 2'b01);
      wait_neg(s + 81);  chk("mrst_mcs_81", bus.mcs_sync, 1);
      wait_neg(s + 225); chk("mrst_done_225", bus.done, 1);
      step();

      for (int i = 0; i < 6000; i++) begin
         bus.start     = ($urandom_range(0, 15) == 0);
         bus.abort     = ($urandom_range(0, (i < 3000) ? 399 : 63) == 0);
         bus.mode      = 1'($urandom_range(0, 1));
         bus.chip_mask = 2'($urandom_range(0, 3));
         step();
      end
      bus.start = 0; bus.abort = 0;
      go(cyc + 260);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
